// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multicycle_ctrl_if : IR fields, ready/zero inputs and datapath strobes     |
// |                      of the RV64I multi-cycle controller                   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
interface multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             zero;
    logic             imem_ready;
    logic             dmem_ready;
    logic             imem_req;
    logic             ir_write;
    logic             pc_write;
    logic             pc_src;
    logic             alu_src;
    logic [1:0]       alu_op;
    logic             dmem_req;
    logic             dmem_we;
    logic             reg_write;
    logic             mem_to_reg;
    logic             error;
    logic [2:0]       state;
    logic [CNT_W-1:0] instret;

    modport master (
        input  opcode, funct3, zero, imem_ready, dmem_ready,
        output imem_req, ir_write, pc_write, pc_src, alu_src, alu_op,
               dmem_req, dmem_we, reg_write, mem_to_reg, error, state, instret
    );

    modport slave (
        output opcode, funct3, zero, imem_ready, dmem_ready,
        input  imem_req, ir_write, pc_write, pc_src, alu_src, alu_op,
               dmem_req, dmem_we, reg_write, mem_to_reg, error, state, instret
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multicycle_ctrl : fetch/decode/exec/mem/wb sequencer for an RV64I subset   |
// |                   with illegal-opcode and memory-timeout detection         |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    multicycle_ctrl_if.master  bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] c_OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [7:0] c_TIMEOUT   = 8'(MEM_TIMEOUT);

    state_t           r_state, w_next;
    logic [7:0]       r_wait_cnt;
    logic [6:0]       r_opcode;
    logic [2:0]       r_funct3;
    logic [CNT_W-1:0] r_instret;

    logic       w_imem_req, w_ir_write, w_pc_write, w_pc_src, w_alu_src;
    logic [1:0] w_alu_op;
    logic       w_dmem_req, w_dmem_we, w_reg_write, w_mem_to_reg, w_error;
    logic       w_wait_inc, w_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= '0;
            r_opcode   <= '0;
            r_funct3   <= '0;
            r_instret  <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_wait_cnt <= '0;
            else if (w_wait_inc)
                r_wait_cnt <= r_wait_cnt + 8'd1;
            if (r_state == S_DECODE) begin
                r_opcode <= bus.opcode;
                r_funct3 <= bus.funct3;
            end
            if (w_pc_write)
                r_instret <= r_instret + CNT_W'(1);
        end
    end

    always_comb begin
        w_next       = r_state;
        w_imem_req   = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_pc_src     = 1'b0;
        w_alu_src    = 1'b0;
        w_alu_op     = 2'b00;
        w_dmem_req   = 1'b0;
        w_dmem_we    = 1'b0;
        w_reg_write  = 1'b0;
        w_mem_to_reg = 1'b0;
        w_error      = 1'b0;
        w_wait_inc   = 1'b0;
        w_timeout    = (r_wait_cnt == c_TIMEOUT);

        case (r_state)
            S_FETCH: begin
                w_imem_req = 1'b1;
                if (bus.imem_ready) begin
                    w_ir_write = 1'b1;
                    w_next     = S_DECODE;
                end else if (w_timeout) begin
                    w_next = S_ERR;
                end else begin
                    w_wait_inc = 1'b1;
                end
            end
            // Live IR fields decide here; later states use the latched copies.
            S_DECODE: begin
                case (bus.opcode)
                    c_OP_RTYPE, c_OP_ITYPE, c_OP_LOAD, c_OP_STORE: w_next = S_EXEC;
                    c_OP_BRANCH: w_next = (bus.funct3 == 3'b000 || bus.funct3 == 3'b001)
                                          ? S_EXEC : S_ERR;
                    default:     w_next = S_ERR;
                endcase
            end
            S_EXEC: begin
                case (r_opcode)
                    c_OP_RTYPE: begin
                        w_alu_op = 2'b10;
                        w_next   = S_WB;
                    end
                    c_OP_ITYPE: begin
                        w_alu_src = 1'b1;
                        w_alu_op  = 2'b10;
                        w_next    = S_WB;
                    end
                    c_OP_LOAD, c_OP_STORE: begin
                        w_alu_src = 1'b1;
                        w_next    = S_MEM;
                    end
                    c_OP_BRANCH: begin
                        w_alu_op   = 2'b01;
                        w_pc_write = 1'b1;
                        w_pc_src   = (r_funct3 == 3'b001) ? ~bus.zero : bus.zero;
                        w_next     = S_FETCH;
                    end
                    default: w_next = S_ERR;
                endcase
            end
            S_MEM: begin
                w_dmem_req = 1'b1;
                w_dmem_we  = (r_opcode == c_OP_STORE);
                w_alu_src  = 1'b1;
                if (bus.dmem_ready) begin
                    if (r_opcode == c_OP_STORE) begin
                        w_pc_write = 1'b1;
                        w_next     = S_FETCH;
                    end else begin
                        w_next = S_WB;
                    end
                end else if (w_timeout) begin
                    w_next = S_ERR;
                end else begin
                    w_wait_inc = 1'b1;
                end
            end
            S_WB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = (r_opcode == c_OP_LOAD);
                w_pc_write   = 1'b1;
                w_next       = S_FETCH;
            end
            S_ERR: begin
                w_error = 1'b1;
            end
            default: w_next = S_ERR;
        endcase
    end

    // Reset lands in FETCH, so strobes are gated to keep imem_req quiet while held.
    assign bus.imem_req   = rst_n & w_imem_req;
    assign bus.ir_write   = rst_n & w_ir_write;
    assign bus.pc_write   = rst_n & w_pc_write;
    assign bus.pc_src     = rst_n & w_pc_src;
    assign bus.alu_src    = rst_n & w_alu_src;
    assign bus.alu_op     = {2{rst_n}} & w_alu_op;
    assign bus.dmem_req   = rst_n & w_dmem_req;
    assign bus.dmem_we    = rst_n & w_dmem_we;
    assign bus.reg_write  = rst_n & w_reg_write;
    assign bus.mem_to_reg = rst_n & w_mem_to_reg;
    assign bus.error      = rst_n & w_error;
    assign bus.state      = r_state;
    assign bus.instret    = r_instret;
endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_multicycle_ctrl : vector table, directed corner cases and random        |
// |                      instruction streams against an instruction-level model|
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_multicycle_ctrl;
    localparam int CNT_W = 32;
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_SD = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    // exp_strobes = {imem_req, ir_write, pc_write, pc_src, alu_src, alu_op[1:0],
    //                dmem_req, dmem_we, reg_write, mem_to_reg}
    typedef struct {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic        zero;
        logic        imem_ready;
        logic        dmem_ready;
        logic [2:0]  exp_state;
        logic [10:0] exp_strobes;
        logic        exp_error;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_bad = 0;
    logic [CNT_W-1:0] exp_instret = '0;
    vec_t tbl[$];
    vec_t vq[$];

    multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();

    multicycle_ctrl #(.MEM_TIMEOUT(15), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no end, want finish");
        $fatal(1);
    end

    function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic z,
                                input logic ir, input logic dr, input logic [2:0] st,
                                input logic [10:0] sb, input logic err);
        vec_t v;
        v.opcode = op; v.funct3 = f3; v.zero = z; v.imem_ready = ir; v.dmem_ready = dr;
        v.exp_state = st; v.exp_strobes = sb; v.exp_error = err;
        return v;
    endfunction

    function automatic logic [10:0] sb(input logic imem_req, input logic ir_write,
                                       input logic pc_write, input logic pc_src,
                                       input logic alu_src, input logic [1:0] alu_op,
                                       input logic dmem_req, input logic dmem_we,
                                       input logic reg_write, input logic mem_to_reg);
        return {imem_req, ir_write, pc_write, pc_src, alu_src, alu_op,
                dmem_req, dmem_we, reg_write, mem_to_reg};
    endfunction

    function automatic logic [6:0] j7();
        return 7'($urandom);
    endfunction
    function automatic logic [2:0] j3();
        return 3'($urandom);
    endfunction
    function automatic logic rb();
        return 1'($urandom);
    endfunction

    task automatic check(input string tag, input vec_t v);
        logic [10:0] got;
        got = {bus.imem_req, bus.ir_write, bus.pc_write, bus.pc_src, bus.alu_src, bus.alu_op,
               bus.dmem_req, bus.dmem_we, bus.reg_write, bus.mem_to_reg};
        n_vec++;
        if (bus.state !== v.exp_state || got !== v.exp_strobes ||
            bus.error !== v.exp_error || bus.instret !== exp_instret) begin
            n_bad++;
            $display("FAIL %s #%0d: got state=%0d strobes=%b error=%b instret=%0d, want state=%0d strobes=%b error=%b instret=%0d",
                     tag, n_vec, bus.state, got, bus.error, bus.instret,
                     v.exp_state, v.exp_strobes, v.exp_error, exp_instret);
        end
    endtask

    // Called just after a falling edge; drives, samples, then waits for the next falling edge.
    task automatic apply(input string tag, input vec_t v);
        bus.opcode     = v.opcode;
        bus.funct3     = v.funct3;
        bus.zero       = v.zero;
        bus.imem_ready = v.imem_ready;
        bus.dmem_ready = v.dmem_ready;
        #1;
        check(tag, v);
        if (v.exp_strobes[8]) exp_instret += 1;
        @(negedge clk);
    endtask

    task automatic run_queue(input string tag);
        foreach (vq[i]) apply(tag, vq[i]);
        vq.delete();
    endtask

    task automatic pulse_reset(input string tag);
        #2;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        exp_instret = '0;
        check(tag, mk(7'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 11'd0, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic gen_head(input logic [6:0] op, input logic [2:0] f3, input int fdly);
        for (int i = 0; i < fdly; i++)
            vq.push_back(mk(j7(), j3(), rb(), 1'b0, rb(), 3'd0, sb(1,0,0,0,0,2'b00,0,0,0,0), 1'b0));
        vq.push_back(mk(j7(), j3(), rb(), 1'b1, rb(), 3'd0, sb(1,1,0,0,0,2'b00,0,0,0,0), 1'b0));
        vq.push_back(mk(op, f3, rb(), rb(), rb(), 3'd1, 11'd0, 1'b0));
    endtask

    // Instruction-level model: expands one legal instruction into its per-cycle trace.
    task automatic gen_instr(input logic [6:0] op, input logic [2:0] f3,
                             input int fdly, input int mdly, input logic z);
        logic is_ld, is_sd, taken;
        is_ld = (op == OP_LD);
        is_sd = (op == OP_SD);
        gen_head(op, f3, fdly);
        if (op == OP_BR) begin
            taken = (f3 == 3'b000) ? z : !z;
            vq.push_back(mk(j7(), j3(), z, rb(), rb(), 3'd2, sb(0,0,1,taken,0,2'b01,0,0,0,0), 1'b0));
        end else if (is_ld || is_sd) begin
            vq.push_back(mk(j7(), j3(), rb(), rb(), rb(), 3'd2, sb(0,0,0,0,1,2'b00,0,0,0,0), 1'b0));
            for (int i = 0; i < mdly; i++)
                vq.push_back(mk(j7(), j3(), rb(), rb(), 1'b0, 3'd3, sb(0,0,0,0,1,2'b00,1,is_sd,0,0), 1'b0));
            vq.push_back(mk(j7(), j3(), rb(), rb(), 1'b1, 3'd3, sb(0,0,is_sd,0,1,2'b00,1,is_sd,0,0), 1'b0));
            if (is_ld)
                vq.push_back(mk(j7(), j3(), rb(), rb(), rb(), 3'd4, sb(0,0,1,0,0,2'b00,0,0,1,1), 1'b0));
        end else begin
            vq.push_back(mk(j7(), j3(), rb(), rb(), rb(), 3'd2, sb(0,0,0,0,op == OP_I,2'b10,0,0,0,0), 1'b0));
            vq.push_back(mk(j7(), j3(), rb(), rb(), rb(), 3'd4, sb(0,0,1,0,0,2'b00,0,0,1,0), 1'b0));
        end
    endtask

    task automatic gen_err(input int n);
        for (int i = 0; i < n; i++)
            vq.push_back(mk(j7(), j3(), rb(), rb(), rb(), 3'd5, 11'd0, 1'b1));
    endtask

    initial begin
        logic [6:0] ops [5];
        logic [6:0] op;
        logic [2:0] f3;
        ops[0] = OP_R; ops[1] = OP_I; ops[2] = OP_LD; ops[3] = OP_SD; ops[4] = OP_BR;

        // addi x1,x0,5 ; beq taken ; bne not taken ; sd with one wait ; ld with three waits
        tbl.push_back(mk(7'h00, 3'd0, 0, 1, 0, 3'd0, 11'b1_1_0_0_0_00_0_0_0_0, 0));
        tbl.push_back(mk(OP_I,  3'd0, 0, 0, 0, 3'd1, 11'b0_0_0_0_0_00_0_0_0_0, 0));
        tbl.push_back(mk(7'h7F, 3'd7, 0, 0, 0, 3'd2, 11'b0_0_0_0_1_10_0_0_0_0, 0));
        tbl.push_back(mk(7'h7F, 3'd7, 0, 0, 0, 3'd4, 11'b0_0_1_0_0_00_0_0_1_0, 0));
        tbl.push_back(mk(7'h00, 3'd0, 0, 1, 0, 3'd0, 11'b1_1_0_0_0_00_0_0_0_0, 0));
        tbl.push_back(mk(OP_BR, 3'd0, 0, 0, 0, 3'd1, 11'b0_0_0_0_0_00_0_0_0_0, 0));
        tbl.push_back(mk(7'h7F, 3'd7, 1, 0, 0, 3'd2, 11'b0_0_1_1_0_01_0_0_0_0, 0));
        tbl.push_back(mk(7'h00, 3'd0, 0, 1, 0, 3'd0, 11'b1_1_0_0_0_00_0_0_0_0, 0));
        tbl.push_back(mk(OP_BR, 3'd1, 0, 0, 0, 3'd1, 11'b0_0_0_0_0_00_0_0_0_0, 0));
        tbl.push_back(mk(7'h7F, 3'd7, 1, 0, 0, 3'd2, 11'b0_0_1_0_0_01_0_0_0_0, 0));
        tbl.push_back(mk(7'h00, 3'd0, 0, 1, 0, 3'd0, 11'b1_1_0_0_0_00_0_0_0_0, 0));
        tbl.push_back(mk(OP_SD, 3'd3, 0, 0, 0, 3'd1, 11'b0_0_0_0_0_00_0_0_0_0, 0));
        tbl.push_back(mk(7'h7F, 3'd7, 0, 0, 0, 3'd2, 11'b0_0_0_0_1_00_0_0_0_0, 0));
        tbl.push_back(mk(7'h7F, 3'd7, 0, 0, 0, 3'd3, 11'b0_0_0_0_1_00_1_1_0_0, 0));
        tbl.push_back(mk(7'h7F, 3'd7, 0, 0, 1, 3'd3, 11'b0_0_1_0_1_00_1_1_0_0, 0));
        tbl.push_back(mk(7'h00, 3'd0, 0, 1, 0, 3'd0, 11'b1_1_0_0_0_00_0_0_0_0, 0));
        tbl.push_back(mk(OP_LD, 3'd3, 0, 0, 0, 3'd1, 11'b0_0_0_0_0_00_0_0_0_0, 0));
        tbl.push_back(mk(7'h7F, 3'd7, 0, 0, 0, 3'd2, 11'b0_0_0_0_1_00_0_0_0_0, 0));
        tbl.push_back(mk(7'h7F, 3'd7, 0, 0, 0, 3'd3, 11'b0_0_0_0_1_00_1_0_0_0, 0));
        tbl.push_back(mk(7'h7F, 3'd7, 0, 0, 0, 3'd3, 11'b0_0_0_0_1_00_1_0_0_0, 0));
        tbl.push_back(mk(7'h7F, 3'd7, 0, 0, 0, 3'd3, 11'b0_0_0_0_1_00_1_0_0_0, 0));
        tbl.push_back(mk(7'h7F, 3'd7, 0, 0, 1, 3'd3, 11'b0_0_0_0_1_00_1_0_0_0, 0));
        tbl.push_back(mk(7'h7F, 3'd7, 0, 0, 0, 3'd4, 11'b0_0_1_0_0_00_0_0_1_1, 0));
        tbl.push_back(mk(7'h00, 3'd0, 0, 0, 0, 3'd0, 11'b1_0_0_0_0_00_0_0_0_0, 0));

        bus.opcode = '0; bus.funct3 = '0; bus.zero = 1'b0;
        bus.imem_ready = 1'b1; bus.dmem_ready = 1'b1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 check("reset", mk(7'd0, 3'd0, 0, 0, 0, 3'd0, 11'd0, 1'b0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) apply("table", tbl[i]);
        pulse_reset("reset_after_table");

        for (int k = 0; k < 40; k++) begin
            op = ops[$urandom_range(0, 4)];
            f3 = (op == OP_BR) ? 3'($urandom_range(0, 1)) : j3();
            gen_instr(op, f3, $urandom_range(0, 15), $urandom_range(0, 15), rb());
        end
        run_queue("random");

        gen_head(7'h7F, 3'd0, 0);
        gen_err(20);
        run_queue("illegal_opcode");
        pulse_reset("reset_from_err");
        vq.push_back(mk(j7(), j3(), 0, 0, 0, 3'd0, sb(1,0,0,0,0,2'b00,0,0,0,0), 1'b0));
        run_queue("fetch_after_err");

        pulse_reset("reset_before_fetch_timeout");
        for (int i = 0; i < 16; i++)
            vq.push_back(mk(j7(), j3(), rb(), 1'b0, rb(), 3'd0, sb(1,0,0,0,0,2'b00,0,0,0,0), 1'b0));
        gen_err(3);
        run_queue("fetch_timeout");

        pulse_reset("reset_before_fetch_edge");
        gen_instr(OP_I, 3'd0, 15, 0, 1'b0);
        gen_instr(OP_LD, 3'd3, 0, 15, 1'b0);
        run_queue("ready_on_last_wait");

        gen_head(OP_SD, 3'd3, 0);
        vq.push_back(mk(j7(), j3(), 0, 0, 0, 3'd2, sb(0,0,0,0,1,2'b00,0,0,0,0), 1'b0));
        for (int i = 0; i < 16; i++)
            vq.push_back(mk(j7(), j3(), rb(), rb(), 1'b0, 3'd3, sb(0,0,0,0,1,2'b00,1,1,0,0), 1'b0));
        gen_err(3);
        run_queue("mem_timeout");

        pulse_reset("reset_before_bad_branch");
        gen_head(OP_BR, 3'd4, 0);
        gen_err(2);
        run_queue("bad_branch_funct3");

        pulse_reset("reset_before_mid_mem");
        gen_instr(OP_R, 3'd0, 0, 0, 1'b0);
        gen_instr(OP_LD, 3'd3, 0, 5, 1'b0);
        for (int i = 0; i < 3; i++) void'(vq.pop_back());
        run_queue("before_mid_mem");
        pulse_reset("mid_mem_reset");
        vq.push_back(mk(j7(), j3(), 0, 0, 0, 3'd0, sb(1,0,0,0,0,2'b00,0,0,0,0), 1'b0));
        run_queue("fetch_after_mid_mem");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
